// File: rtl/issue_a_loader_pkg.sv
// issue_a_loader_pkg: shared widths, ring depth and loader state encodings
package issue_a_loader_pkg;
    localparam int DATA_W     = 18;
    localparam int ADDR_W     = 10;
    localparam int CNT_W      = 13;
    localparam int SLOT_W     = ADDR_W - 1;
    localparam int RING_DEPTH = 2 ** SLOT_W;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
endpackage

// File: rtl/issue_a_loader_if.sv
// issue_a_loader_if: activation stream valid/ready handshake
interface issue_a_loader_if;
    import issue_a_loader_pkg::*;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    modport master (output in_valid, in_data, input in_ready);
    modport slave (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/issue_a_loader_ring_credit.sv
// issue_a_loader_ring_credit: grants a stream slot while job words remain and the ring has room
module issue_a_loader_ring_credit
    import issue_a_loader_pkg::*;
(
    input  logic             en_i,
    input  logic [CNT_W-1:0] accepted_i,
    input  logic [CNT_W-1:0] dsp_i,
    input  logic [CNT_W-1:0] target_i,
    output logic             ready_o
);
    logic [CNT_W-1:0] occ;
    // occupancy is the count of accepted words the DSP has not consumed yet
    always_comb begin
        occ     = accepted_i - dsp_i;
        ready_o = en_i && (accepted_i < target_i) && (occ < CNT_W'(RING_DEPTH));
    end
endmodule

// File: rtl/issue_a_loader.sv
// issue_a_loader: streams activation words into the lower RAMB half and publishes the alloc counter
module issue_a_loader
    import issue_a_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              job_start_i,
    input  logic [CNT_W-1:0]  job_len_i,
    issue_a_loader_if.slave   s,
    output logic              ramb_wr_en_o,
    output logic [ADDR_W-1:0] ramb_wr_addr_o,
    output logic [DATA_W-1:0] ramb_wr_data_o,
    output logic [CNT_W-1:0]  issue_a_alloc_counter_o,
    input  logic [CNT_W-1:0]  issue_a_dsp_counter_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   accepted_q, target_q, alloc_q;
    logic               wr_en_q, done_q, err_q;
    logic [SLOT_W-1:0]  wr_slot_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [CNT_W:0]     sum;
    logic               over, take, start_ok;

    issue_a_loader_ring_credit u_credit (
        .en_i       (state_q == LOAD),
        .accepted_i (accepted_q),
        .dsp_i      (issue_a_dsp_counter_i),
        .target_i   (target_q),
        .ready_o    (s.in_ready)
    );

    // next state plus job admission: a carry out of alloc+len means the counters would wrap
    always_comb begin
        sum      = {1'b0, alloc_q} + {1'b0, job_len_i};
        over     = sum[CNT_W];
        start_ok = job_start_i && !over;
        take     = s.in_valid && s.in_ready;
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = start_ok ? (job_len_i == '0 ? DONE : LOAD) : IDLE;
            LOAD:    state_d = accepted_q == target_q ? DRAIN : LOAD;
            DRAIN:   state_d = issue_a_dsp_counter_i >= target_q ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // state, counters and the one-deep write register that commits an accepted word a cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            accepted_q <= '0;
            target_q   <= '0;
            alloc_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_slot_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_ok) target_q <= sum[CNT_W-1:0];
            if (take) begin
                accepted_q <= accepted_q + 1'b1;
                wr_slot_q  <= accepted_q[SLOT_W-1:0];
                wr_data_q  <= s.in_data;
            end
            wr_en_q <= take;
            if (wr_en_q) alloc_q <= alloc_q + 1'b1;
            done_q <= state_q == DONE;
            err_q  <= state_q == IDLE && job_start_i && over;
        end
    end

    assign ramb_wr_en_o            = wr_en_q;
    assign ramb_wr_addr_o          = {1'b0, wr_slot_q};
    assign ramb_wr_data_o          = wr_data_q;
    assign issue_a_alloc_counter_o = alloc_q;
    assign busy_o                  = state_q != IDLE;
    assign done_o                  = done_q;
    assign err_o                   = err_q;
endmodule

// File: tb/tb_issue_a_loader.sv
// tb_issue_a_loader: table-driven jobs plus directed ring-full, zero, overflow and reset sequences
module tb_issue_a_loader;
    logic        clk = 0;
    logic        rst = 1;
    logic        job_start = 0;
    logic [12:0] job_len = 0;
    logic [12:0] dsp = 0;
    logic        wr_en, busy, done, err;
    logic [9:0]  wr_addr;
    logic [17:0] wr_data;
    logic [12:0] alloc;

    issue_a_loader_if lif();

    issue_a_loader dut (
        .clk                     (clk),
        .rst                     (rst),
        .job_start_i             (job_start),
        .job_len_i               (job_len),
        .s                       (lif),
        .ramb_wr_en_o            (wr_en),
        .ramb_wr_addr_o          (wr_addr),
        .ramb_wr_data_o          (wr_data),
        .issue_a_alloc_counter_o (alloc),
        .issue_a_dsp_counter_i   (dsp),
        .busy_o                  (busy),
        .done_o                  (done),
        .err_o                   (err)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data; int c;} wr_t;
    typedef struct {bit do_rst; int len; bit sparse; int first_addr; int exp_alloc; bit hold;} job_t;

    wr_t  wr_q[$];
    int   checks = 0, failures = 0;
    int   done_cnt = 0, err_cnt = 0, cyc_n = 0;
    bit   dsp_auto = 1;
    int   dsp_cap = 8191;

    // write/done/err monitor sampled mid-cycle
    always @(negedge clk) begin
        cyc_n++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (wr_en) wr_q.push_back('{int'(wr_addr), int'(wr_data), cyc_n});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (dsp_auto && dsp < alloc && int'(dsp) < dsp_cap) dsp = dsp + 1'b1;
    endtask

    task automatic reset_dut();
        rst = 1; dsp = 0; lif.in_valid = 0; lif.in_data = 0; job_start = 0;
        cyc(); cyc();
        rst = 0;
    endtask

    task automatic start(input int len);
        job_start = 1; job_len = 13'(len);
        cyc();
        job_start = 0; job_len = 0;
    endtask

    task automatic feed(input int n, input int first, input bit sparse, input int budget, output int sent);
        int ph = 0;
        bit take;
        sent = 0;
        while (sent < n && ph < budget) begin
            lif.in_valid = sparse ? (ph % 2 == 0) : 1'b1;
            lif.in_data  = 18'(first + sent);
            @(negedge clk);
            take = lif.in_valid && lif.in_ready;
            cyc();
            if (take) sent++;
            ph++;
        end
        lif.in_valid = 0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            cyc();
            n++;
        end
        chk("done_seen", int'(done_cnt != d0), 1);
    endtask

    job_t jobs[4];

    initial begin
        int sent, d0, e0;
        lif.in_valid = 0;
        lif.in_data  = 0;
        jobs[0] = '{1, 4, 0, 0, 4, 0};
        jobs[1] = '{1, 3, 0, 0, 3, 0};
        jobs[2] = '{0, 2, 0, 3, 5, 1};
        jobs[3] = '{0, 3, 1, 5, 8, 0};

        reset_dut();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_alloc", alloc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        chk("rst_in_ready", lif.in_ready, 0);
        cyc();

        for (int j = 0; j < 4; j++) begin
            if (jobs[j].do_rst) reset_dut();
            dsp_auto = 1;
            dsp_cap = jobs[j].hold ? jobs[j].exp_alloc - 1 : 8191;
            wr_q.delete();
            d0 = done_cnt;
            start(jobs[j].len);
            chk("job_busy", busy, 1);
            feed(jobs[j].len, 1, jobs[j].sparse, 40, sent);
            chk("job_sent", sent, jobs[j].len);
            if (jobs[j].hold) begin
                repeat (6) cyc();
                chk("hold_no_done", done_cnt - d0, 0);
                chk("hold_busy", busy, 1);
                dsp_cap = 8191;
            end
            wait_done(d0, 40);
            cyc(); cyc();
            chk("job_done_once", done_cnt - d0, 1);
            chk("job_alloc", alloc, jobs[j].exp_alloc);
            chk("job_idle", busy, 0);
            chk("job_writes", wr_q.size(), jobs[j].len);
            for (int k = 0; k < wr_q.size(); k++) begin
                chk("job_addr", wr_q[k].addr, jobs[j].first_addr + k);
                chk("job_data", wr_q[k].data, 1 + k);
                if (k > 0) chk("job_spacing", wr_q[k].c - wr_q[k-1].c, jobs[j].sparse ? 2 : 1);
            end
        end

        wr_q.delete();
        d0 = done_cnt;
        start(0);
        chk("zero_busy", busy, 1);
        chk("zero_done_early", done, 0);
        cyc();
        chk("zero_done", done, 1);
        chk("zero_idle", busy, 0);
        cyc();
        chk("zero_done_off", done, 0);
        chk("zero_no_writes", wr_q.size(), 0);
        chk("zero_alloc", alloc, 8);

        reset_dut();
        dsp_auto = 0;
        wr_q.delete();
        start(600);
        feed(600, 1, 0, 530, sent);
        chk("ring_sent", sent, 512);
        cyc(); cyc();
        chk("ring_alloc", alloc, 512);
        chk("ring_writes", wr_q.size(), 512);
        chk("ring_last_addr", wr_q[511].addr, 511);
        @(negedge clk);
        chk("ring_full_ready", lif.in_ready, 0);
        cyc();
        dsp = 1;
        @(negedge clk);
        chk("ring_release_ready", lif.in_ready, 1);
        cyc();
        feed(1, 513, 0, 10, sent);
        chk("ring_sent_one", sent, 1);
        cyc();
        chk("ring_writes_513", wr_q.size(), 513);
        chk("ring_reuse_addr", wr_q[512].addr, 0);
        chk("ring_reuse_data", wr_q[512].data, 513);
        @(negedge clk);
        chk("ring_full_again", lif.in_ready, 0);
        cyc();

        reset_dut();
        dsp_auto = 1;
        start(8);
        feed(3, 1, 0, 20, sent);
        chk("mid_sent", sent, 3);
        rst = 1; dsp = 0;
        cyc();
        chk("mid_wr_en", wr_en, 0);
        chk("mid_alloc", alloc, 0);
        chk("mid_busy", busy, 0);
        rst = 0;
        cyc();
        chk("mid_wr_en_after", wr_en, 0);
        wr_q.delete();
        d0 = done_cnt;
        start(2);
        feed(2, 1, 0, 20, sent);
        wait_done(d0, 40);
        chk("mid_new_writes", wr_q.size(), 2);
        chk("mid_new_addr", wr_q[0].addr, 0);
        chk("mid_new_alloc", alloc, 2);

        reset_dut();
        d0 = done_cnt;
        start(8190);
        feed(8190, 0, 0, 9000, sent);
        chk("big_sent", sent, 8190);
        wait_done(d0, 100);
        chk("big_alloc", alloc, 8190);
        e0 = err_cnt;
        start(5);
        chk("ovf_err", err, 1);
        chk("ovf_idle", busy, 0);
        @(negedge clk);
        chk("ovf_in_ready", lif.in_ready, 0);
        cyc();
        chk("ovf_err_off", err, 0);
        chk("ovf_err_once", err_cnt - e0, 1);
        d0 = done_cnt;
        start(1);
        chk("max_busy", busy, 1);
        chk("max_no_err", err, 0);
        feed(1, 7, 0, 10, sent);
        wait_done(d0, 40);
        chk("max_alloc", alloc, 8191);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
